// File: rtl/vector_result_checker.sv
// vector_result_checker: response-side checker for unit-test vector flows.
// The stimulus side pushes expected results (value + NZCV flags) into an
// internal FIFO. DUT results are popped and compared in order, and the block
// keeps pass/fail statistics and the index of the first failing vector.
//
// Optional feature macro: CHK_FLAGS_EN
//   defined   - flags are stored and take part in the compare
//   undefined - only the value is stored and compared; flag ports are ignored
//
// state | meaning
// IDLE  | after reset, handshakes closed, waiting for start
// RUN   | accepting expected vectors and DUT results, comparing
// DONE  | finish seen and FIFO drained; verdict held until next start
module vector_result_checker #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             finish,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [WIDTH-1:0] exp_result,
  input  logic [3:0]       exp_flags,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [WIDTH-1:0] res_result,
  input  logic [3:0]       res_flags,
  output logic             mismatch,
  output logic [CNTW-1:0]  pass_cnt,
  output logic [CNTW-1:0]  fail_cnt,
  output logic [CNTW-1:0]  first_fail_idx,
  output logic             first_fail_vld,
  output logic             done,
  output logic             all_pass
);

  localparam int AW = $clog2(DEPTH);
`ifdef CHK_FLAGS_EN
  localparam int EW = WIDTH + 4;
`else
  localparam int EW = WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [AW:0]     wptr;
  logic [AW:0]     rptr;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            match;
  logic            finish_latch;
  logic [CNTW-1:0] vec_idx;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   wr_entry;
  logic [EW-1:0]   head;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  assign exp_ready = (state == RUN) && !full;
  assign res_ready = (state == RUN) && !empty;

  // start wins over any handshake offered in the same cycle
  assign push = exp_valid && exp_ready && !start;
  assign pop  = res_valid && res_ready && !start;

  assign head = mem[rptr[AW-1:0]];

`ifdef CHK_FLAGS_EN
  assign wr_entry = {exp_flags, exp_result};
  assign match    = ({res_flags, res_result} == head);
`else
  assign wr_entry = exp_result;
  assign match    = (res_result == head);
  // flag ports stay on the interface but carry no information in this build
  logic unused_flags;
  assign unused_flags = ^{exp_flags, res_flags};
`endif

  assign all_pass = done && (fail_cnt == '0) && (pass_cnt != '0);

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wr_entry;
  end

  // control FSM, pointers, statistics and registered verdict outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wptr           <= '0;
      rptr           <= '0;
      finish_latch   <= 1'b0;
      vec_idx        <= '0;
      mismatch       <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      done           <= 1'b0;
    end else if (start) begin
      state          <= RUN;
      wptr           <= '0;
      rptr           <= '0;
      finish_latch   <= 1'b0;
      vec_idx        <= '0;
      mismatch       <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      done           <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        RUN: begin
          if (push) wptr <= wptr + (AW+1)'(1);
          if (pop) begin
            rptr    <= rptr + (AW+1)'(1);
            vec_idx <= vec_idx + CNTW'(1);
            if (match) begin
              if (pass_cnt != '1) pass_cnt <= pass_cnt + CNTW'(1);
            end else begin
              mismatch <= 1'b1;
              if (fail_cnt != '1) fail_cnt <= fail_cnt + CNTW'(1);
              if (!first_fail_vld) begin
                first_fail_idx <= vec_idx;
                first_fail_vld <= 1'b1;
              end
            end
          end
          if (finish) finish_latch <= 1'b1;
          if (finish_latch && empty && !pop) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_result_checker.sv
// Testbench for vector_result_checker: scoreboard of expected vectors plus a
// small reference model of the statistics, checked every cycle after the edge.
module tb_vector_result_checker;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CNTW  = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             finish = 1'b0;
  logic             exp_valid = 1'b0;
  logic             exp_ready;
  logic [WIDTH-1:0] exp_result = '0;
  logic [3:0]       exp_flags = '0;
  logic             res_valid = 1'b0;
  logic             res_ready;
  logic [WIDTH-1:0] res_result = '0;
  logic [3:0]       res_flags = '0;
  logic             mismatch;
  logic [CNTW-1:0]  pass_cnt;
  logic [CNTW-1:0]  fail_cnt;
  logic [CNTW-1:0]  first_fail_idx;
  logic             first_fail_vld;
  logic             done;
  logic             all_pass;

  vector_result_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_result(exp_result), .exp_flags(exp_flags),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_result(res_result), .res_flags(res_flags),
    .mismatch(mismatch), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_idx(first_fail_idx), .first_fail_vld(first_fail_vld),
    .done(done), .all_pass(all_pass)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [35:0]     sb_q[$];
  logic            m_run = 1'b0;
  logic [CNTW-1:0] m_pass = '0;
  logic [CNTW-1:0] m_fail = '0;
  logic [CNTW-1:0] m_idx = '0;
  logic [CNTW-1:0] m_ffi = '0;
  logic            m_ffv = 1'b0;

  task automatic model_clear();
    sb_q.delete();
    m_pass = '0; m_fail = '0; m_idx = '0; m_ffi = '0; m_ffv = 1'b0;
  endtask

  // one clock of stimulus with scoreboard push/pop and post-edge comparison
  task automatic cyc(input logic ev, input logic [31:0] er, input logic [3:0] ef,
                     input logic rv, input logic [31:0] rr, input logic [3:0] rf);
    logic e_hs, r_hs, e_rdy, r_rdy, exp_mis, match;
    logic [35:0] head;
    exp_valid = ev; exp_result = er; exp_flags = ef;
    res_valid = rv; res_result = rr; res_flags = rf;
    e_rdy = m_run && (sb_q.size() < DEPTH);
    r_rdy = m_run && (sb_q.size() > 0);
    e_hs = ev && e_rdy;
    r_hs = rv && r_rdy;
    checks++;
    if (exp_ready !== e_rdy) begin
      errors++; $display("FAIL exp_ready: got %b expected %b", exp_ready, e_rdy);
    end
    checks++;
    if (res_ready !== r_rdy) begin
      errors++; $display("FAIL res_ready: got %b expected %b", res_ready, r_rdy);
    end
    exp_mis = 1'b0;
    if (r_hs) begin
      head = sb_q.pop_front();
`ifdef CHK_FLAGS_EN
      match = (rr == head[31:0]) && (rf == head[35:32]);
`else
      match = (rr == head[31:0]);
`endif
      if (match) begin
        if (m_pass != '1) m_pass++;
      end else begin
        exp_mis = 1'b1;
        if (m_fail != '1) m_fail++;
        if (!m_ffv) begin m_ffi = m_idx; m_ffv = 1'b1; end
      end
      m_idx++;
    end
    if (e_hs) sb_q.push_back({ef, er});
    @(posedge clk); #1;
    exp_valid = 1'b0; res_valid = 1'b0;
    checks++;
    if (mismatch !== exp_mis) begin
      errors++; $display("FAIL mismatch: got %b expected %b", mismatch, exp_mis);
    end
    checks++;
    if (pass_cnt !== m_pass || fail_cnt !== m_fail) begin
      errors++;
      $display("FAIL counters: got pass=%0d fail=%0d expected pass=%0d fail=%0d",
               pass_cnt, fail_cnt, m_pass, m_fail);
    end
    checks++;
    if (first_fail_vld !== m_ffv || (m_ffv && first_fail_idx !== m_ffi)) begin
      errors++;
      $display("FAIL first_fail: got vld=%b idx=%0d expected vld=%b idx=%0d",
               first_fail_vld, first_fail_idx, m_ffv, m_ffi);
    end
  endtask

  task automatic push_vec(input logic [31:0] v, input logic [3:0] f);
    cyc(1'b1, v, f, 1'b0, 32'h0, 4'h0);
  endtask

  // return the head of the scoreboard, optionally corrupting the value
  task automatic pop_vec(input logic corrupt);
    logic [35:0] h;
    h = sb_q[0];
    cyc(1'b0, 32'h0, 4'h0, 1'b1, h[31:0] ^ {31'h0, corrupt}, h[35:32]);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
    m_run = 1'b1;
    checks++;
    if ({done, mismatch, first_fail_vld, pass_cnt, fail_cnt} !== '0) begin
      errors++;
      $display("FAIL start_clear: got done=%b mis=%b ffv=%b pass=%0d fail=%0d expected all 0",
               done, mismatch, first_fail_vld, pass_cnt, fail_cnt);
    end
  endtask

  task automatic finish_and_wait();
    int n;
    logic got;
    logic exp_ap;
    n = 1; got = 1'b0;
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) begin got = 1'b1; break; end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!got || n > 2) begin
      errors++; $display("FAIL done_latency: got done=%b after %0d cycles expected 1 within 2", done, n);
    end
    m_run = 1'b0;
    exp_ap = (m_fail == '0) && (m_pass != '0);
    checks++;
    if (all_pass !== exp_ap) begin
      errors++; $display("FAIL all_pass: got %b expected %b", all_pass, exp_ap);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({exp_ready, res_ready, mismatch, pass_cnt, fail_cnt, first_fail_idx,
         first_fail_vld, done, all_pass} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got er=%b rr=%b mis=%b pass=%0d fail=%0d ffi=%0d ffv=%b done=%b ap=%b expected all 0",
               exp_ready, res_ready, mismatch, pass_cnt, fail_cnt, first_fail_idx,
               first_fail_vld, done, all_pass);
    end
  endtask

  task automatic test_basic_pass();
    do_start();
    push_vec(32'h0000_0005, 4'h0);
    push_vec(32'hFFFF_FFFF, 4'h8);
    push_vec(32'h0000_0000, 4'h4);
    repeat (3) pop_vec(1'b0);
    finish_and_wait();
    checks++;
    if (pass_cnt !== 16'd3 || fail_cnt !== 16'd0) begin
      errors++; $display("FAIL basic_counts: got pass=%0d fail=%0d expected 3 0", pass_cnt, fail_cnt);
    end
  endtask

  task automatic test_fail_capture();
    do_start();
    for (int i = 0; i < 4; i++) push_vec(32'h100 + i, 4'(i));
    for (int i = 0; i < 4; i++) pop_vec((i == 1) || (i == 3));
    finish_and_wait();
    checks++;
    if (pass_cnt !== 16'd2 || fail_cnt !== 16'd2 || first_fail_idx !== 16'd1 ||
        first_fail_vld !== 1'b1 || all_pass !== 1'b0) begin
      errors++;
      $display("FAIL fail_capture: got pass=%0d fail=%0d ffi=%0d ffv=%b ap=%b expected 2 2 1 1 0",
               pass_cnt, fail_cnt, first_fail_idx, first_fail_vld, all_pass);
    end
  endtask

  task automatic test_full_empty();
    do_start();
    cyc(1'b0, 32'h0, 4'h0, 1'b1, 32'h1, 4'h0);
    cyc(1'b1, 32'hA0, 4'h1, 1'b1, 32'hA0, 4'h1);
    for (int i = 1; i < DEPTH; i++) push_vec(32'hA0 + i, 4'(i));
    cyc(1'b1, 32'hDEAD, 4'h0, 1'b0, 32'h0, 4'h0);
    checks++;
    if (exp_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready: got %b expected 0", exp_ready);
    end
    repeat (4) pop_vec(1'b0);
    for (int i = 0; i < 20; i++) begin
      logic [35:0] h;
      h = sb_q[0];
      cyc(1'b1, 32'h1000 + i, 4'(i), 1'b1, h[31:0], h[35:32]);
      checks++;
      if (sb_q.size() != 4 || exp_ready !== 1'b1 || res_ready !== 1'b1) begin
        errors++;
        $display("FAIL steady_occupancy: got er=%b rr=%b model=%0d expected 1 1 4",
                 exp_ready, res_ready, sb_q.size());
      end
    end
    while (sb_q.size() > 0) pop_vec(1'b0);
    finish_and_wait();
    checks++;
    if (pass_cnt !== 16'd28 || fail_cnt !== 16'd0) begin
      errors++; $display("FAIL wrap_order: got pass=%0d fail=%0d expected 28 0", pass_cnt, fail_cnt);
    end
  endtask

  task automatic test_flag_only();
    do_start();
    push_vec(32'h10, 4'h2);
    cyc(1'b0, 32'h0, 4'h0, 1'b1, 32'h10, 4'h0);
    finish_and_wait();
    checks++;
`ifdef CHK_FLAGS_EN
    if (fail_cnt !== 16'd1 || pass_cnt !== 16'd0) begin
      errors++; $display("FAIL flag_only: got pass=%0d fail=%0d expected 0 1", pass_cnt, fail_cnt);
    end
`else
    if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0) begin
      errors++; $display("FAIL flag_only: got pass=%0d fail=%0d expected 1 0", pass_cnt, fail_cnt);
    end
`endif
  endtask

  task automatic test_reset_restart();
    do_start();
    pop_vec_guard();
    for (int i = 0; i < 3; i++) push_vec(32'h55 + i, 4'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_run = 1'b0;
    model_clear();
    checks++;
    if ({exp_ready, res_ready, mismatch, pass_cnt, fail_cnt, first_fail_idx,
         first_fail_vld, done, all_pass} !== '0) begin
      errors++; $display("FAIL midrun_reset: got pass=%0d fail=%0d er=%b rr=%b done=%b expected all 0",
                         pass_cnt, fail_cnt, exp_ready, res_ready, done);
    end
    cyc(1'b1, 32'h77, 4'h0, 1'b1, 32'h77, 4'h0);
    do_start();
    push_vec(32'h9, 4'h3);
    pop_vec(1'b1);
    push_vec(32'hA, 4'h3);
    pop_vec(1'b0);
    finish_and_wait();
    cyc(1'b1, 32'h1, 4'h0, 1'b1, 32'h1, 4'h0);
    do_start();
    checks++;
    if (done !== 1'b0 || all_pass !== 1'b0) begin
      errors++; $display("FAIL restart: got done=%b ap=%b expected 0 0", done, all_pass);
    end
  endtask

  // a result offered on an empty FIFO right after start must not be consumed
  task automatic pop_vec_guard();
    cyc(1'b0, 32'h0, 4'h0, 1'b1, 32'h55, 4'h1);
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_fail_capture();
    test_full_empty();
    test_flag_only();
    test_reset_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
